led_pattern_ctrl: RTL and testbench
===================================

# led_pattern_ctrl

Sequencer for the 4-LED board bank: owns the step prescaler, selects one of four display patterns and a speed level from single-cycle key pulses, and drives the active-low LED bus. It sits between the debounced key pulses and the LED pins and replaces the fixed-pattern rotate counters with a single runtime-configurable controller.

## Interface
- TICK_DIV, default 25_000_000: step period in clk cycles at speed 0; must be a multiple of 8 and at least 8.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- mode_next  in  1  one-cycle pulse: advance to the next pattern.
- speed_up  in  1  one-cycle pulse: raise the speed level, saturating at 3.
- speed_down  in  1  one-cycle pulse: lower the speed level, saturating at 0.
- pause  in  1  one-cycle pulse: toggle the paused state.
- led  out  4  LED drive, active-low (0 = lit).
- mode  out  2  current pattern: 0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 BLINK.
- speed  out  2  current speed level.
- paused  out  1  1 while stepping is frozen.
- step  out  1  one-cycle strobe, high in the cycle in which `led` takes a new step value.

## Operation
- Reset values: led = 4'b1110, mode = ROT_L, speed = 0, paused = 0, step = 0, prescaler = 0, direction = forward.
- Step period P = TICK_DIV >> speed.
  - P = TICK_DIV, TICK_DIV/2, TICK_DIV/4, TICK_DIV/8 for speed 0..3.
- Prescaler:
  - Increments every clock while not paused and holds while paused.
  - When prescaler >= P-1, it loads 0 and a step occurs.
  - The >= compare makes a speed increase take effect without overrun.
- On each step, the next `led` depends on mode:
  - ROT_L: `{led[2:0],led[3]}`, giving 1110, 1101, 1011, 0111, 1110, ...
  - ROT_R: `{led[0],led[3:1]}`, giving 1110, 0111, 1011, 1101, 1110, ...
  - BOUNCE: if led == 0111, rotate right and set direction = reverse. If led == 1110, rotate left and set direction = forward. Otherwise rotate in the current direction. Each end value is shown for exactly one step: 1110, 1101, 1011, 0111, 1011, 1101, 1110, 1101, ...
  - BLINK: `led <= ~led`, starting 0000 (all lit), then 1111, 0000, ...
- Mode change (mode_next):
  - Mode advances 0→1→2→3→0.
  - Prescaler is cleared to 0 and direction is set to forward.
  - led loads 4'b1110, or 4'b0000 when entering BLINK.
  - step is not asserted.
- Speed pulses:
  - speed_up raises speed by 1, saturating at 3; speed_down lowers it by 1, saturating at 0.
  - speed_up and speed_down in the same cycle: speed unchanged.
  - The prescaler is not cleared by a speed change.
- Pause: each pulse toggles `paused`. While paused, led, prescaler and direction hold. Mode and speed pulses are still accepted.
- Simultaneous events in one cycle:
  - mode_next overrides a coincident step: the mode reload wins and step stays 0.
  - pause together with mode_next: both are applied, so the reload occurs and paused toggles.
  - pause together with a step that would otherwise occur: pause takes priority. The step is suppressed if paused becomes 1, and a step occurs only if paused becomes 0.
- Reset mid-operation: all state returns to the reset values on the next edge, regardless of the inputs.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- After rst is deasserted, the first led change is on the P-th rising edge, where P is the period at speed 0. step is high for the single cycle following that edge, aligned with the new led value.
- Input pulses take effect on the edge at which they are sampled. mode, speed, paused and led reflect the change in the next cycle.
- Steady-state step spacing is exactly P cycles.
- After a speed change, the next step occurs within at most P_new cycles.

## Structure
- Shared package/header `led_pkg`:
  - Mode encodings MODE_ROT_L/ROT_R/BOUNCE/BLINK.
  - LED_START = 4'b1110, LED_ALL_ON = 4'b0000, LED_ALL_OFF = 4'b1111.
  - SPEED_MAX = 2'd3.
- One sub-module, `led_step_gen`: a prescaler with inputs speed, hold and clear, and a step output. The pattern/mode FSM stays in the top level.

## Test plan
All scenarios use TICK_DIV = 16.
- Reset, then run for 64 cycles: led shows 1110, 1101, 1011, 0111, 1110, with changes at edges 16/32/48/64 and step high one cycle at each.
- Issue mode_next twice to reach BOUNCE, then run 8 steps: the sequence is 1110, 1101, 1011, 0111, 1011, 1101, 1110, 1101, with no repeated end value.
- Issue speed_up ×4: speed = 3 (saturates) and steps are 2 cycles apart. Then pulse speed_up and speed_down in the same cycle: speed stays 3.
- Pulse pause at prescaler = 5, hold 40 cycles, then pulse pause again: led is unchanged throughout, and the next step arrives 10 cycles after the resume.
- Pulse mode_next in the cycle where prescaler = 15 in ROT_L: mode = ROT_R, led = 1110, step = 0, and the next step is 16 cycles later, giving led = 0111.
- Assert rst for one cycle while in BLINK at speed 2 and paused: all outputs return to led = 1110, mode = 0, speed = 0, paused = 0.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern sequencer: mode and direction
// encodings, LED bus constants and small pattern helpers.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_ROT_L  = 2'd0,
        MODE_ROT_R  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_REV = 1'b1
    } dir_e;

    // LED bus is active-low: a 0 bit is a lit LED.
    localparam logic [3:0] LED_START   = 4'b1110;
    localparam logic [3:0] LED_LAST    = 4'b0111;
    localparam logic [3:0] LED_ALL_ON  = 4'b0000;
    localparam logic [3:0] LED_ALL_OFF = 4'b1111;

    localparam logic [1:0] SPEED_MAX = 2'd3;

    // Lit LED moves towards bit 3.
    function automatic logic [3:0] rot_l(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

    // Lit LED moves towards bit 0.
    function automatic logic [3:0] rot_r(input logic [3:0] v);
        return {v[0], v[3:1]};
    endfunction

    // Pattern order wraps from BLINK back to ROT_L.
    function automatic mode_e mode_after(input mode_e m);
        mode_e n;
        unique case (m)
            MODE_ROT_L:  n = MODE_ROT_R;
            MODE_ROT_R:  n = MODE_BOUNCE;
            MODE_BOUNCE: n = MODE_BLINK;
            default:     n = MODE_ROT_L;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/led_step_gen.sv
// Step prescaler: counts clocks and fires a one-cycle step request each
// time the count reaches the period selected by the speed level.
module led_step_gen
    import led_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed_i,
    input  logic       hold_i,
    input  logic       clear_i,
    output logic       step_o
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    if ((TICK_DIV < 8) || ((TICK_DIV % 8) != 0)) begin : g_bad_div
        $error("led_step_gen: TICK_DIV must be a multiple of 8 and at least 8");
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] period_m1;
    logic             at_end;

    // Terminal count for the current speed: P = TICK_DIV >> speed, minus one.
    always_comb begin
        unique case (speed_i)
            2'd0:    period_m1 = CNT_W'(TICK_DIV - 1);
            2'd1:    period_m1 = CNT_W'((TICK_DIV / 2) - 1);
            2'd2:    period_m1 = CNT_W'((TICK_DIV / 4) - 1);
            default: period_m1 = CNT_W'((TICK_DIV / 8) - 1);
        endcase
    end

    // >= rather than == so a jump to a faster speed cannot overrun the
    // shorter period when the count is already past its new end.
    assign at_end = (cnt_q >= period_m1);

    // Next count and step request; clear beats hold, hold beats counting.
    always_comb begin
        cnt_d  = cnt_q;
        step_o = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (!hold_i) begin
            if (at_end) begin
                cnt_d  = '0;
                step_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern sequencer: tracks pattern mode, speed level and pause state
// from key pulses and steps the active-low 4-LED bus on prescaler strobes.
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_next,
    input  logic       speed_up,
    input  logic       speed_down,
    input  logic       pause,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic [1:0] speed,
    output logic       paused,
    output logic       step
);

    mode_e      mode_q,   mode_d;
    dir_e       dir_q,    dir_d;
    logic [3:0] led_q,    led_d;
    logic [1:0] speed_q,  speed_d;
    logic       paused_q, paused_d;
    logic       step_q,   step_d;
    logic       step_fire;

    // The prescaler sees the pause state being entered this cycle, so a
    // pause pulse coinciding with a step suppresses it and a resume pulse
    // lets it through.
    assign paused_d = paused_q ^ pause;

    led_step_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_step_gen (
        .clk     (clk),
        .rst     (rst),
        .speed_i (speed_q),
        .hold_i  (paused_d),
        .clear_i (mode_next),
        .step_o  (step_fire)
    );

    // Next-state for mode, speed, direction, LED pattern and step strobe.
    always_comb begin
        mode_d  = mode_q;
        speed_d = speed_q;
        dir_d   = dir_q;
        led_d   = led_q;
        step_d  = 1'b0;

        // Opposing speed pulses in one cycle cancel out.
        if (speed_up && !speed_down) begin
            if (speed_q != SPEED_MAX) begin
                speed_d = speed_q + 2'd1;
            end
        end else if (speed_down && !speed_up) begin
            if (speed_q != 2'd0) begin
                speed_d = speed_q - 2'd1;
            end
        end

        // A mode change reloads the pattern and wins over a coincident step.
        if (mode_next) begin
            mode_d = mode_after(mode_q);
            dir_d  = DIR_FWD;
            led_d  = (mode_d == MODE_BLINK) ? LED_ALL_ON : LED_START;
        end else if (step_fire) begin
            step_d = 1'b1;
            unique case (mode_q)
                MODE_ROT_L: led_d = rot_l(led_q);
                MODE_ROT_R: led_d = rot_r(led_q);
                MODE_BOUNCE: begin
                    // Turn around on the end values so each is shown once.
                    if (led_q == LED_LAST) begin
                        led_d = rot_r(led_q);
                        dir_d = DIR_REV;
                    end else if (led_q == LED_START) begin
                        led_d = rot_l(led_q);
                        dir_d = DIR_FWD;
                    end else if (dir_q == DIR_FWD) begin
                        led_d = rot_l(led_q);
                    end else begin
                        led_d = rot_r(led_q);
                    end
                end
                default: begin
                    // BLINK only ever holds all-on or all-off.
                    led_d = (led_q == LED_ALL_ON) ? LED_ALL_OFF : LED_ALL_ON;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= MODE_ROT_L;
            dir_q    <= DIR_FWD;
            led_q    <= LED_START;
            speed_q  <= 2'd0;
            paused_q <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            led_q    <= led_d;
            speed_q  <= speed_d;
            paused_q <= paused_d;
            step_q   <= step_d;
        end
    end

    assign led    = led_q;
    assign mode   = mode_q;
    assign speed  = speed_q;
    assign paused = paused_q;
    assign step   = step_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Testbench for led_pattern_ctrl with TICK_DIV = 16.
module tb_led_pattern_ctrl;

    localparam int TD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode_next = 1'b0;
    logic       speed_up = 1'b0;
    logic       speed_down = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] led;
    logic [1:0] mode;
    logic [1:0] speed;
    logic       paused;
    logic       step;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: LED value is derived from the mode and the
    // number of steps taken since the mode was entered.
    int m_mode   = 0;
    int m_speed  = 0;
    int m_idx    = 0;
    int m_cnt    = 0;
    bit m_paused = 0;
    bit m_step   = 0;

    logic [9:0] obs;
    assign obs = {led, mode, speed, paused, step};

    led_pattern_ctrl #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode_next  (mode_next),
        .speed_up   (speed_up),
        .speed_down (speed_down),
        .pause      (pause),
        .led        (led),
        .mode       (mode),
        .speed      (speed),
        .paused     (paused),
        .step       (step)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Lit-LED position as a function of mode and step count.
    function automatic logic [3:0] pat(input int md, input int idx);
        int pos;
        case (md)
            0: pos = idx % 4;
            1: pos = (4 - (idx % 4)) % 4;
            2: begin
                case (idx % 6)
                    0: pos = 0;
                    1: pos = 1;
                    2: pos = 2;
                    3: pos = 3;
                    4: pos = 2;
                    default: pos = 1;
                endcase
            end
            default: return (idx % 2 == 1) ? 4'b1111 : 4'b0000;
        endcase
        return ~(4'b0001 << pos);
    endfunction

    function automatic logic [9:0] expv();
        return {pat(m_mode, m_idx), 2'(m_mode), 2'(m_speed), m_paused, m_step};
    endfunction

    task automatic model_clock(input bit mn, input bit su, input bit sd, input bit pz, input bit r);
        int per;
        bit np;
        if (r) begin
            m_mode = 0; m_speed = 0; m_paused = 0; m_idx = 0; m_cnt = 0; m_step = 0;
            return;
        end
        per    = TD >> m_speed;
        np     = m_paused ^ pz;
        m_step = 0;
        if (mn) begin
            m_mode = (m_mode + 1) % 4;
            m_idx  = 0;
            m_cnt  = 0;
        end else if (!np) begin
            if (m_cnt >= per - 1) begin
                m_cnt  = 0;
                m_idx  = m_idx + 1;
                m_step = 1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        if (su && !sd && m_speed < 3) m_speed = m_speed + 1;
        else if (sd && !su && m_speed > 0) m_speed = m_speed - 1;
        m_paused = np;
    endtask

    // Drive one cycle of input pulses, advance the model, sample 1 time unit after the edge.
    task automatic tick(input bit mn, input bit su, input bit sd, input bit pz);
        mode_next  = mn;
        speed_up   = su;
        speed_down = sd;
        pause      = pz;
        @(posedge clk);
        model_clock(mn, su, sd, pz, rst);
        #1;
        mode_next  = 0;
        speed_up   = 0;
        speed_down = 0;
        pause      = 0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_rl [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        rst = 1'b1;
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        n_chk++;
        if (obs !== 10'b1110_00_00_0_0) begin
            n_fail++;
            $display("FAIL reset_state: got %b required %b", obs, 10'b1110_00_00_0_0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            tick(0, 0, 0, 0);
            n_chk++;
            if (obs !== expv()) begin
                n_fail++;
                $display("FAIL rotl_cycle%0d: got %b required %b", k, obs, expv());
            end
            if (k % 16 == 0) begin
                n_chk++;
                if ({led, step} !== {exp_rl[k/16 - 1], 1'b1}) begin
                    n_fail++;
                    $display("FAIL rotl_edge%0d: got led=%b step=%b required led=%b step=1",
                             k, led, step, exp_rl[k/16 - 1]);
                end
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] exp_b [8] = '{4'b1101, 4'b1011, 4'b0111, 4'b1011,
                                 4'b1101, 4'b1110, 4'b1101, 4'b1011};
        int n = 0;
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        n_chk++;
        if ({mode, led, step} !== {2'd2, 4'b1110, 1'b0}) begin
            n_fail++;
            $display("FAIL bounce_entry: got mode=%0d led=%b step=%b required mode=2 led=1110 step=0",
                     mode, led, step);
        end
        for (int c = 0; c < 200 && n < 8; c++) begin
            tick(0, 0, 0, 0);
            n_chk++;
            if (obs !== expv()) begin
                n_fail++;
                $display("FAIL bounce_cycle: got %b required %b", obs, expv());
            end
            if (step) begin
                n_chk++;
                if (led !== exp_b[n]) begin
                    n_fail++;
                    $display("FAIL bounce_step%0d: got %b required %b", n, led, exp_b[n]);
                end
                n++;
            end
        end
        n_chk++;
        if (n != 8) begin
            n_fail++;
            $display("FAIL bounce_step_count: got %0d required 8", n);
        end
    endtask

    task automatic test_speed();
        int gap;
        for (int i = 0; i < 4; i++) tick(0, 1, 0, 0);
        n_chk++;
        if (speed !== 2'd3) begin
            n_fail++;
            $display("FAIL speed_saturate_hi: got %0d required 3", speed);
        end
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 40 && !step; c++) tick(0, 0, 0, 0);
            gap = 0;
            for (int c = 0; c < 40; c++) begin
                tick(0, 0, 0, 0);
                gap++;
                if (step) break;
            end
            n_chk++;
            if (gap != 2 || !step) begin
                n_fail++;
                $display("FAIL speed3_spacing: got %0d required 2", gap);
            end
        end
        tick(0, 1, 1, 0);
        n_chk++;
        if (speed !== 2'd3) begin
            n_fail++;
            $display("FAIL speed_both_pulses: got %0d required 3", speed);
        end
        for (int i = 0; i < 4; i++) tick(0, 0, 1, 0);
        n_chk++;
        if (obs !== expv() || speed !== 2'd0) begin
            n_fail++;
            $display("FAIL speed_saturate_lo: got %b required %b", obs, expv());
        end
    endtask

    task automatic test_pause();
        logic [3:0] held;
        int n = 0;
        bit bad = 0;
        for (int c = 0; c < 40 && m_cnt != 5; c++) tick(0, 0, 0, 0);
        held = led;
        tick(0, 0, 0, 1);
        n_chk++;
        if ({paused, led} !== {1'b1, held}) begin
            n_fail++;
            $display("FAIL pause_enter: got paused=%b led=%b required paused=1 led=%b", paused, led, held);
        end
        for (int c = 0; c < 40; c++) begin
            tick(0, 0, 0, 0);
            if (led !== held || step !== 1'b0 || paused !== 1'b1) bad = 1;
        end
        n_chk++;
        if (bad) begin
            n_fail++;
            $display("FAIL pause_hold: got led=%b step=%b required led=%b step=0", led, step, held);
        end
        tick(0, 0, 0, 1);
        n_chk++;
        if (paused !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_resume: got %b required 0", paused);
        end
        for (int c = 0; c < 40; c++) begin
            tick(0, 0, 0, 0);
            n++;
            if (step) break;
        end
        n_chk++;
        if (n != 10 || !step) begin
            n_fail++;
            $display("FAIL pause_resume_latency: got %0d required 10", n);
        end
    endtask

    task automatic test_mode_at_wrap();
        bit early = 0;
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        for (int c = 0; c < 40 && m_cnt != 15; c++) tick(0, 0, 0, 0);
        n_chk++;
        if (mode !== 2'd0) begin
            n_fail++;
            $display("FAIL wrap_pre_mode: got %0d required 0", mode);
        end
        tick(1, 0, 0, 0);
        n_chk++;
        if ({mode, led, step} !== {2'd1, 4'b1110, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_mode_next: got mode=%0d led=%b step=%b required mode=1 led=1110 step=0",
                     mode, led, step);
        end
        for (int c = 1; c < 16; c++) begin
            tick(0, 0, 0, 0);
            if (step) early = 1;
        end
        tick(0, 0, 0, 0);
        n_chk++;
        if (early || {led, step} !== {4'b0111, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap_next_step: got led=%b step=%b early=%b required led=0111 step=1 early=0",
                     led, step, early);
        end
    endtask

    task automatic test_reset_mid();
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 0, 0, 1);
        n_chk++;
        if ({mode, speed, paused} !== {2'd3, 2'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL pre_reset_state: got mode=%0d speed=%0d paused=%b required 3 2 1",
                     mode, speed, paused);
        end
        rst = 1'b1;
        tick(1, 1, 0, 1);
        rst = 1'b0;
        n_chk++;
        if (obs !== 10'b1110_00_00_0_0) begin
            n_fail++;
            $display("FAIL reset_mid: got %b required %b", obs, 10'b1110_00_00_0_0);
        end
    endtask

    task automatic test_random();
        bit mn, su, sd, pz;
        for (int c = 0; c < 3000; c++) begin
            mn = ($urandom_range(39) == 0);
            su = ($urandom_range(15) == 0);
            sd = ($urandom_range(15) == 0);
            pz = ($urandom_range(23) == 0);
            rst = ($urandom_range(599) == 0);
            tick(mn, su, sd, pz);
            rst = 1'b0;
            n_chk++;
            if (obs !== expv()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %b required %b", c, obs, expv());
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_bounce();
        test_speed();
        test_pause();
        test_mode_at_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
